// File: rtl/execute_stage.sv
// Pipeline EXECUTE stage: ALU, address calc and an optional iterative 32-cycle shift-add multiplier.
// Build option: define EXECUTE_MUL_EN to include the multiplier FSM; otherwise op 101 yields 0 in one cycle.
module execute_stage #(
  parameter int ADDR_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  DX_op,
  input  logic [31:0] DX_A,
  input  logic [31:0] DX_B,
  input  logic [31:0] DX_RT,
  input  logic [4:0]  DX_RD,
  input  logic        DX_MemToReg,
  input  logic        DX_MemWrite,
  input  logic        DX_bnoWB,
  output logic [31:0] XM_ALUout,
  output logic [31:0] XM_RT,
  output logic [4:0]  XM_RD,
  output logic        XM_MemToReg,
  output logic        XM_MemWrite,
  output logic        XM_bnoWB,
  output logic        stall
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_SLT   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_MEM   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [31:0] ADDR_MASK = (32'd1 << ADDR_BITS) - 32'd1;

  logic [31:0] alu_res;

  // Single-cycle result; MUL falls to zero here and is handled separately when built in.
  always_comb begin
    alu_res = 32'd0;
    case (DX_op)
      OP_ADD:   alu_res = DX_A + DX_B;
      OP_SUB:   alu_res = DX_A - DX_B;
      OP_AND:   alu_res = DX_A & DX_B;
      OP_OR:    alu_res = DX_A | DX_B;
      OP_SLT:   alu_res = {31'd0, ($signed(DX_A) < $signed(DX_B))};
      OP_MEM:   alu_res = (DX_A + DX_B) & ADDR_MASK;
      OP_PASSB: alu_res = DX_B;
      default:  alu_res = 32'd0;
    endcase
  end

`ifdef EXECUTE_MUL_EN

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic [4:0]  cap_rd;
  logic        cap_bnowb;
  logic [31:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

  // Stall covers the accept cycle plus iterations 0..30; the final iteration lets decode advance.
  assign stall = !rst && ((state == IDLE) ? (DX_op == OP_MUL) : (cnt != 5'd31));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= 32'd0;
      mplier      <= 32'd0;
      acc         <= 32'd0;
      cnt         <= 5'd0;
      cap_rd      <= 5'd0;
      cap_bnowb   <= 1'b0;
      XM_ALUout   <= 32'd0;
      XM_RT       <= 32'd0;
      XM_RD       <= 5'd0;
      XM_MemToReg <= 1'b0;
      XM_MemWrite <= 1'b0;
      XM_bnoWB    <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (DX_op == OP_MUL) begin
            mcand       <= DX_A;
            mplier      <= DX_B;
            acc         <= 32'd0;
            cnt         <= 5'd0;
            cap_rd      <= DX_RD;
            cap_bnowb   <= DX_bnoWB;
            state       <= MUL;
            XM_ALUout   <= 32'd0;
            XM_RD       <= 5'd0;
            XM_MemToReg <= 1'b0;
            XM_MemWrite <= 1'b0;
            XM_bnoWB    <= 1'b0;
          end else begin
            XM_ALUout   <= alu_res;
            XM_RT       <= DX_RT;
            XM_RD       <= DX_RD;
            XM_MemToReg <= DX_MemToReg;
            XM_MemWrite <= DX_MemWrite;
            XM_bnoWB    <= DX_bnoWB;
          end
        end
        MUL: begin
          acc         <= acc_next;
          mcand       <= mcand << 1;
          mplier      <= mplier >> 1;
          XM_MemToReg <= 1'b0;
          XM_MemWrite <= 1'b0;
          if (cnt == 5'd31) begin
            XM_ALUout <= acc_next;
            XM_RD     <= cap_rd;
            XM_bnoWB  <= cap_bnowb;
            cnt       <= 5'd0;
            state     <= IDLE;
          end else begin
            XM_ALUout <= 32'd0;
            XM_RD     <= 5'd0;
            XM_bnoWB  <= 1'b0;
            cnt       <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign stall = 1'b0;

  // Without the multiplier every op, including 101, is a plain one-cycle register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      XM_ALUout   <= 32'd0;
      XM_RT       <= 32'd0;
      XM_RD       <= 5'd0;
      XM_MemToReg <= 1'b0;
      XM_MemWrite <= 1'b0;
      XM_bnoWB    <= 1'b0;
    end else if (en) begin
      XM_ALUout   <= alu_res;
      XM_RT       <= DX_RT;
      XM_RD       <= DX_RD;
      XM_MemToReg <= DX_MemToReg;
      XM_MemWrite <= DX_MemWrite;
      XM_bnoWB    <= DX_bnoWB;
    end
  end

`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; multiplier scenarios run when EXECUTE_MUL_EN is defined.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  DX_op;
  logic [31:0] DX_A;
  logic [31:0] DX_B;
  logic [31:0] DX_RT;
  logic [4:0]  DX_RD;
  logic        DX_MemToReg;
  logic        DX_MemWrite;
  logic        DX_bnoWB;
  logic [31:0] XM_ALUout;
  logic [31:0] XM_RT;
  logic [4:0]  XM_RD;
  logic        XM_MemToReg;
  logic        XM_MemWrite;
  logic        XM_bnoWB;
  logic        stall;

  int errors = 0;
  int checks = 0;
  int steps;

  execute_stage #(.ADDR_BITS(7)) dut (
    .clk(clk), .rst(rst), .en(en),
    .DX_op(DX_op), .DX_A(DX_A), .DX_B(DX_B), .DX_RT(DX_RT), .DX_RD(DX_RD),
    .DX_MemToReg(DX_MemToReg), .DX_MemWrite(DX_MemWrite), .DX_bnoWB(DX_bnoWB),
    .XM_ALUout(XM_ALUout), .XM_RT(XM_RT), .XM_RD(XM_RD),
    .XM_MemToReg(XM_MemToReg), .XM_MemWrite(XM_MemWrite), .XM_bnoWB(XM_bnoWB),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rt, input logic [4:0] rd,
                           input logic m2r, input logic mw, input logic nowb);
    DX_op = op; DX_A = a; DX_B = b; DX_RT = rt; DX_RD = rd;
    DX_MemToReg = m2r; DX_MemWrite = mw; DX_bnoWB = nowb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and let one edge register it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] rt, input logic [4:0] rd,
                               input logic m2r, input logic mw, input logic nowb);
    setInputs(op, a, b, rt, rd, m2r, mw, nowb);
    step();
  endtask

  // Runs a multiply and returns how many edges elapsed until its result showed up (0 = never).
  task automatic runMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] prod, input int gap_at, input int gap_len,
                        output int n);
    n = 0;
    setInputs(3'b101, a, b, 32'd0, rd, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      en = !(k > gap_at && k <= gap_at + gap_len);
      step();
      if (XM_RD == rd && XM_ALUout == prod) begin
        n = k;
        break;
      end
    end
    en = 1'b1;
    setInputs(3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    setInputs(3'b101, 32'd7, 32'd6, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    step();
    step();
    checkOutput("reset_alu", XM_ALUout, 32'd0);
    checkOutput("reset_rd", {27'd0, XM_RD}, 32'd0);
    checkOutput("reset_ctl", {29'd0, XM_MemToReg, XM_MemWrite, XM_bnoWB}, 32'd0);
    setInputs(3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("add_wrap", XM_ALUout, 32'd0);
    checkOutput("add_rd", {27'd0, XM_RD}, 32'd5);
    checkOutput("add_mw", {31'd0, XM_MemWrite}, 32'd0);

    applyStimulus(3'b001, 32'd5, 32'd7, 32'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    checkOutput("sub_wrap", XM_ALUout, 32'hFFFFFFFE);
    checkOutput("sub_nowb", {31'd0, XM_bnoWB}, 32'd1);

    applyStimulus(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("and", XM_ALUout, 32'h00F0_1200);

    applyStimulus(3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("or", XM_ALUout, 32'hFFF0_FF34);

    applyStimulus(3'b110, 32'd200, 32'd3, 32'h0000DEAD, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mem_addr", XM_ALUout, 32'd75);
    checkOutput("mem_mw", {31'd0, XM_MemWrite}, 32'd1);
    checkOutput("mem_rt", XM_RT, 32'h0000DEAD);

    applyStimulus(3'b110, 32'h8000_0000, 32'd127, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    checkOutput("load_addr", XM_ALUout, 32'd127);
    checkOutput("load_m2r", {31'd0, XM_MemToReg}, 32'd1);

    applyStimulus(3'b100, 32'hFFFFFFFD, 32'd2, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("slt_neg", XM_ALUout, 32'd1);
    applyStimulus(3'b100, 32'd2, 32'hFFFFFFFD, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("slt_pos", XM_ALUout, 32'd0);

    applyStimulus(3'b111, 32'd9, 32'h1234_5678, 32'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("passb", XM_ALUout, 32'h1234_5678);

    en = 1'b0;
    applyStimulus(3'b000, 32'd1, 32'd1, 32'd0, 5'd31, 1'b0, 1'b0, 1'b0);
    checkOutput("en_hold_alu", XM_ALUout, 32'h1234_5678);
    checkOutput("en_hold_rd", {27'd0, XM_RD}, 32'd8);
    en = 1'b1;

`ifdef EXECUTE_MUL_EN
    // 7 * -6 with full cycle-by-cycle stall/bubble checks.
    setInputs(3'b101, 32'd7, 32'hFFFFFFFA, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    #1;
    for (int c = 0; c < 32; c++) begin
      checkOutput($sformatf("mul_stall_c%0d", c), {31'd0, stall}, 32'd1);
      step();
      checkOutput($sformatf("mul_bubble_rd_c%0d", c), {27'd0, XM_RD}, 32'd0);
      checkOutput($sformatf("mul_bubble_alu_c%0d", c), XM_ALUout, 32'd0);
    end
    checkOutput("mul_stall_c32", {31'd0, stall}, 32'd0);
    step();
    checkOutput("mul_result", XM_ALUout, 32'hFFFFFFD6);
    checkOutput("mul_rd", {27'd0, XM_RD}, 32'd9);
    checkOutput("mul_no_mem", {30'd0, XM_MemToReg, XM_MemWrite}, 32'd0);
    applyStimulus(3'b000, 32'd1, 32'd1, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("after_mul_add", XM_ALUout, 32'd2);
    checkOutput("after_mul_rd", {27'd0, XM_RD}, 32'd4);

    runMul(32'd3, 32'd5, 5'd3, 32'd15, 1000, 0, steps);
    checkOutput("mul_nogap_latency", steps, 32'd33);
    runMul(32'd3, 32'd5, 5'd3, 32'd15, 11, 4, steps);
    checkOutput("mul_gap_latency", steps, 32'd37);

    // Abort a multiply with reset at iteration 20, then check a fresh one.
    setInputs(3'b101, 32'h1234, 32'h10, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) step();
    checkOutput("pre_abort_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_stall", {31'd0, stall}, 32'd0);
    checkOutput("abort_alu", XM_ALUout, 32'd0);
    checkOutput("abort_rd", {27'd0, XM_RD}, 32'd0);
    #1;
    rst = 1'b0;
    runMul(32'd2, 32'd2, 5'd10, 32'd4, 1000, 0, steps);
    checkOutput("mul_after_abort", steps, 32'd33);
`else
    setInputs(3'b101, 32'd7, 32'd6, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("op101_stall", {31'd0, stall}, 32'd0);
    step();
    checkOutput("op101_alu", XM_ALUout, 32'd0);
    checkOutput("op101_rd", {27'd0, XM_RD}, 32'd9);
    checkOutput("op101_mw", {31'd0, XM_MemWrite}, 32'd1);
    applyStimulus(3'b000, 32'd1, 32'd1, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("op101_next_add", XM_ALUout, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
